spi_ow_cmd_scheduler: RTL and testbench

//  Sequences 1-Wire bus operations from 16-bit command frames received by the SPI slave.

---
 rtl/spi_ow_cmd_scheduler.sv | 155 +++++++++++++++
 tb/tb_spi_ow_cmd_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ow_cmd_scheduler.sv
// Queues 16-bit SPI command frames and sequences them onto a 1-Wire master.
// Results and status snapshots are loaded into the SPI response register.
module spi_ow_cmd_scheduler #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_spi_rd_buf,
    input  logic        i_spi_done,
    output logic [7:0]  o_spi_wr_buf,
    output logic        o_ow_start,
    output logic [1:0]  o_ow_op,
    output logic [7:0]  o_ow_wdata,
    input  logic        i_ow_busy,
    input  logic        i_ow_done,
    input  logic [7:0]  i_ow_rdata,
    input  logic        i_ow_presence,
    output logic [7:0]  o_status,
    output logic        o_irq
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {StIdle, StDecode, StWait} state_e;

    logic [15:0]   r_fifo [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_spi_done_d;

    state_e        r_state;
    logic [15:0]   r_cmd;
    logic [15:0]   r_timer;
    logic [7:0]    r_resp;
    logic          r_ow_start;
    logic [1:0]    r_ow_op;
    logic [7:0]    r_ow_wdata;
    logic          r_ovf;
    logic          r_bad_op;
    logic          r_tmo;
    logic          r_presence;

    logic          w_push;
    logic          w_push_ok;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic [7:0]    w_status;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = i_spi_done & ~r_spi_done_d;
    // Fullness is judged before any same-cycle pop.
    assign w_push_ok = w_push & ~w_full;
    assign w_pop     = (r_state == StIdle) & ~w_empty;
    assign w_busy    = (r_state != StIdle) | ~w_empty;
    assign w_status  = {w_busy, w_empty, w_full, r_ovf, r_bad_op, r_tmo, r_presence, 1'b0};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_spi_done_d <= 1'b0;
        end else begin
            r_spi_done_d <= i_spi_done;
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= i_spi_rd_buf;
                r_wr_ptr         <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_cmd      <= '0;
            r_timer    <= '0;
            r_resp     <= 8'h00;
            r_ow_start <= 1'b0;
            r_ow_op    <= 2'd0;
            r_ow_wdata <= 8'h00;
            r_ovf      <= 1'b0;
            r_bad_op   <= 1'b0;
            r_tmo      <= 1'b0;
            r_presence <= 1'b0;
        end else begin
            r_ow_start <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (!w_empty) begin
                        r_cmd   <= r_fifo[r_rd_ptr];
                        r_state <= StDecode;
                    end
                end
                StDecode: begin
                    case (r_cmd[15:8])
                        8'h00: r_state <= StIdle;
                        8'h01, 8'h02, 8'h03: begin
                            if (!i_ow_busy) begin
                                r_ow_start <= 1'b1;
                                r_ow_op    <= r_cmd[9:8] - 2'd1;
                                r_ow_wdata <= (r_cmd[15:8] == 8'h02) ? r_cmd[7:0] : 8'h00;
                                r_timer    <= '0;
                                r_state    <= StWait;
                            end
                        end
                        8'h04: begin
                            r_resp   <= w_status;
                            r_ovf    <= 1'b0;
                            r_bad_op <= 1'b0;
                            r_tmo    <= 1'b0;
                            r_state  <= StIdle;
                        end
                        default: begin
                            r_bad_op <= 1'b1;
                            r_state  <= StIdle;
                        end
                    endcase
                end
                StWait: begin
                    if (i_ow_done) begin
                        if (r_ow_op == 2'd2) r_resp <= i_ow_rdata;
                        if (r_ow_op == 2'd0) r_presence <= i_ow_presence;
                        r_state <= StIdle;
                    end else if (r_timer == 16'(TIMEOUT - 1)) begin
                        r_tmo   <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end
                default: r_state <= StIdle;
            endcase
            // A new overflow outranks a same-cycle status clear.
            if (w_push & w_full) r_ovf <= 1'b1;
        end
    end

    assign o_spi_wr_buf = r_resp;
    assign o_ow_start   = r_ow_start;
    assign o_ow_op      = r_ow_op;
    assign o_ow_wdata   = r_ow_wdata;
    assign o_status     = w_status;
    assign o_irq        = r_ovf | r_bad_op | r_tmo;

endmodule

// File: tb/tb_spi_ow_cmd_scheduler.sv
// Directed scenarios plus random traffic, all checked every cycle against a queue-based model.
module tb_spi_ow_cmd_scheduler;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rd_buf = '0;
    logic        spi_done = 1'b0;
    logic        ow_busy = 1'b0;
    logic        ow_done = 1'b0;
    logic [7:0]  ow_rdata = '0;
    logic        ow_presence = 1'b0;
    logic [7:0]  wr_buf;
    logic        ow_start;
    logic [1:0]  ow_op;
    logic [7:0]  ow_wdata;
    logic [7:0]  status;
    logic        irq;

    spi_ow_cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(rst), .i_spi_rd_buf(rd_buf), .i_spi_done(spi_done),
        .o_spi_wr_buf(wr_buf), .o_ow_start(ow_start), .o_ow_op(ow_op), .o_ow_wdata(ow_wdata),
        .i_ow_busy(ow_busy), .i_ow_done(ow_done), .i_ow_rdata(ow_rdata),
        .i_ow_presence(ow_presence), .o_status(status), .o_irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model: queued frames, the command in hand, and the outstanding bus operation.
    logic [15:0] mq[$];
    bit          m_prev_done;
    bit          m_have_cmd;
    bit          m_on_bus;
    logic [15:0] m_cmd;
    int          m_issue_cyc;
    bit          m_ovf, m_bad, m_tmo, m_pres;
    logic [7:0]  m_resp;
    bit          m_start;
    logic [1:0]  m_op;
    logic [7:0]  m_wdata;

    function automatic logic [7:0] m_status();
        bit busy = m_have_cmd || m_on_bus || (mq.size() != 0);
        return {busy, mq.size() == 0, mq.size() == DEPTH, m_ovf, m_bad, m_tmo, m_pres, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        bit push, full_now;
        logic [7:0] snap, opc;
        if (rst) begin
            mq.delete();
            m_prev_done = 0; m_have_cmd = 0; m_on_bus = 0;
            m_ovf = 0; m_bad = 0; m_tmo = 0; m_pres = 0;
            m_resp = 8'h00; m_start = 0; m_op = 2'd0; m_wdata = 8'h00;
            return;
        end
        push        = spi_done && !m_prev_done;
        m_prev_done = spi_done;
        full_now    = (mq.size() == DEPTH);
        snap        = m_status();
        m_start     = 0;
        if (m_on_bus) begin
            if (ow_done) begin
                if (m_op == 2'd2) m_resp = ow_rdata;
                if (m_op == 2'd0) m_pres = ow_presence;
                m_on_bus = 0;
            end else if (cyc - m_issue_cyc >= int'(TIMEOUT)) begin
                m_tmo    = 1;
                m_on_bus = 0;
            end
        end else if (m_have_cmd) begin
            opc = m_cmd[15:8];
            if (opc >= 8'd1 && opc <= 8'd3) begin
                if (!ow_busy) begin
                    m_start     = 1;
                    m_op        = 2'(opc - 8'd1);
                    m_wdata     = (opc == 8'd2) ? m_cmd[7:0] : 8'h00;
                    m_on_bus    = 1;
                    m_issue_cyc = cyc;
                    m_have_cmd  = 0;
                end
            end else begin
                if (opc == 8'd4) begin
                    m_resp = snap;
                    m_ovf = 0; m_bad = 0; m_tmo = 0;
                end else if (opc != 8'd0) begin
                    m_bad = 1;
                end
                m_have_cmd = 0;
            end
        end else if (mq.size() > 0) begin
            m_cmd      = mq.pop_front();
            m_have_cmd = 1;
        end
        if (push) begin
            if (full_now) m_ovf = 1;
            else mq.push_back(rd_buf);
        end
    endtask

    task automatic tick();
        model_step();
        cyc++;
        @(posedge clk);
        @(negedge clk);
        chk("ow_start", ow_start, m_start);
        chk("ow_op", ow_op, m_op);
        chk("ow_wdata", ow_wdata, m_wdata);
        chk("spi_wr_buf", wr_buf, m_resp);
        chk("status", status, m_status());
        chk("irq", irq, m_ovf | m_bad | m_tmo);
    endtask

    task automatic push(input logic [15:0] frame);
        rd_buf   = frame;
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        tick();
    endtask

    task automatic drain(input int maxc, input bit give_done, output int starts);
        bit idle = 0;
        starts = 0;
        for (int i = 0; i < maxc; i++) begin
            tick();
            if (ow_start) starts++;
            ow_done  = give_done && ow_start;
            ow_rdata = 8'($urandom);
            if (!status[7] && !ow_done) begin
                idle = 1;
                break;
            end
        end
        ow_done = 1'b0;
        if (!idle) chk("drain_bound", 1, 0);
    endtask

    function automatic logic [15:0] rand_frame();
        logic [7:0] opc;
        case ($urandom_range(0, 9))
            0:       opc = 8'h00;
            1:       opc = 8'h01;
            2, 3:    opc = 8'h02;
            4, 5:    opc = 8'h03;
            6, 9:    opc = 8'h04;
            7:       opc = 8'h7F;
            default: opc = 8'($urandom_range(5, 255));
        endcase
        return {opc, 8'($urandom)};
    endfunction

    initial begin
        int n, starts;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("reset_status", status, 8'h40);
        chk("reset_resp", wr_buf, 8'h00);
        chk("reset_irq", irq, 1'b0);

        // Read byte, including the SPI_DONE-to-OW_START latency.
        rd_buf   = 16'h0300;
        spi_done = 1'b1;
        n = 0;
        while (!ow_start && n < 10) begin
            tick();
            n++;
            if (n == 1) spi_done = 1'b0;
        end
        chk("start_latency", n, 3);
        chk("read_op", ow_op, 2'd2);
        ow_done  = 1'b1;
        ow_rdata = 8'h5A;
        tick();
        ow_done = 1'b0;
        chk("read_resp", wr_buf, 8'h5A);

        // Write held off by a busy bus.
        ow_busy = 1'b1;
        push(16'h02A5);
        starts = 0;
        repeat (10) begin
            tick();
            if (ow_start) starts++;
        end
        chk("busy_holds", starts, 0);
        ow_busy = 1'b0;
        n = 0;
        while (!ow_start && n < 5) begin
            tick();
            n++;
        end
        chk("write_wdata", ow_wdata, 8'hA5);
        chk("write_op", ow_op, 2'd1);
        ow_done = 1'b1;
        tick();
        ow_done = 1'b0;
        chk("write_resp_kept", wr_buf, 8'h5A);

        // Overflow, then a status command reports and clears it.
        ow_busy = 1'b1;
        repeat (6) push(16'h0211);
        chk("ovf_flag", status[4], 1'b1);
        chk("ovf_irq", irq, 1'b1);
        chk("ovf_full", status[5], 1'b1);
        ow_busy = 1'b0;
        drain(300, 1'b1, starts);
        chk("ovf_ops_run", starts, 5);
        push(16'h0400);
        drain(10, 1'b0, starts);
        chk("status_resp_ovf", wr_buf[4], 1'b1);
        chk("status_clears_irq", irq, 1'b0);

        // Bus reset that never completes.
        push(16'h0100);
        drain(TIMEOUT + 20, 1'b0, starts);
        chk("tmo_flag", status[2], 1'b1);
        chk("tmo_idle", status[7], 1'b0);
        push(16'h0300);
        drain(20, 1'b1, starts);
        chk("after_tmo_runs", starts, 1);

        // Bad opcode seen through a status snapshot.
        push(16'h7F00);
        push(16'h0400);
        drain(20, 1'b0, starts);
        chk("bad_op_resp", wr_buf[3], 1'b1);
        chk("bad_op_cleared", status[3], 1'b0);
        chk("bad_op_irq", irq, 1'b0);

        // Reset while waiting with two frames queued.
        push(16'h0300);
        tick();
        chk("wait_start", ow_start, 1'b1);
        push(16'h0200);
        push(16'h0201);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        starts = 0;
        repeat (10) begin
            tick();
            if (ow_start) starts++;
        end
        chk("rst_no_start", starts, 0);
        chk("rst_status", status, 8'h40);
        chk("rst_resp", wr_buf, 8'h00);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if (spi_done) begin
                if ($urandom_range(0, 1) == 0) spi_done = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
                spi_done = 1'b1;
                rd_buf   = rand_frame();
            end
            if ($urandom_range(0, 9) == 0) ow_busy = ~ow_busy;
            ow_done     = ($urandom_range(0, 5) == 0);
            ow_rdata    = 8'($urandom);
            ow_presence = 1'($urandom);
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
